// File: rtl/ps2_host_writer_pkg.sv
// Shared PS/2 definitions: transmitter states, command bytes and the
// microsecond-to-cycle conversion used to size the protocol timers.
package ps2_host_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_DONE,
        ST_FAIL
    } tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

    function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
        return (clk_hz / 32'd1_000_000) * us;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge strobe.
// Flops reset to 1 so an idle (pulled-up) line never produces a fall.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = line_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_writer.sv
// PS/2 host-to-device command transmitter (inhibit / request-to-send / device-clocked).
// Optional PS2_TX_RETRY_EN: failed attempts are retried up to MAX_RETRY times.
module ps2_host_writer
    import ps2_host_writer_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned INHIBIT_US = 100,
    parameter int unsigned TIMEOUT_US = 15000
`ifdef PS2_TX_RETRY_EN
    ,
    parameter int unsigned MAX_RETRY  = 2
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2CLK,
    input  logic       ps2DATA,
    output logic       ps2ClkLow,
    output logic       ps2DataLow,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    output logic       busy,
    output logic       txDone,
    output logic       txErr
);

    localparam int unsigned INHIBIT_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
    localparam int unsigned TIMEOUT_CYC = us_to_cycles(CLK_HZ, TIMEOUT_US);
    localparam int unsigned INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYC);

    logic clk_level, clk_fall, data_level, data_fall_unused;

    ps2_line_sync u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2CLK),
        .level_o(clk_level),
        .fall_o (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2DATA),
        .level_o(data_level),
        .fall_o (data_fall_unused)
    );

    tx_state_e        state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_q, par_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             clk_low_q, clk_low_d;
    logic             data_low_q, data_low_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             attempt_fail;
    logic             timed_out;
    logic             next_bit;

`ifdef PS2_TX_RETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            to_cnt_q   <= to_cnt_d;
            clk_low_q  <= clk_low_d;
            data_low_q <= data_low_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef PS2_TX_RETRY_EN
            retry_cnt_q <= retry_cnt_d;
`endif
        end
    end

    // A fall always wins over the timeout: the device was still clocking.
    assign timed_out = (to_cnt_q >= TO_LAST) && !clk_fall;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        bit_cnt_d    = bit_cnt_q;
        inh_cnt_d    = inh_cnt_q;
        to_cnt_d     = to_cnt_q;
        attempt_fail = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_cnt_d  = retry_cnt_q;
`endif
        if (state_q == ST_SEND || state_q == ST_ACK || state_q == ST_WAIT_IDLE) begin
            if (clk_fall)
                to_cnt_d = '0;
            else if (to_cnt_q != TO_MAX)
                to_cnt_d = to_cnt_q + TO_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (txValid) begin
                    shreg_d   = txData;
                    par_d     = ~^txData;
                    bit_cnt_d = '0;
                    inh_cnt_d = '0;
`ifdef PS2_TX_RETRY_EN
                    retry_cnt_d = '0;
`endif
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt_q == INH_LAST)
                    state_d = ST_REQ;
                else
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
            end
            ST_REQ: begin
                to_cnt_d = '0;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9)
                        state_d = ST_ACK;
                end else if (timed_out) begin
                    attempt_fail = 1'b1;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    if (!data_level)
                        state_d = ST_WAIT_IDLE;
                    else
                        attempt_fail = 1'b1;
                end else if (timed_out) begin
                    attempt_fail = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_level && data_level)
                    state_d = ST_DONE;
                else if (timed_out)
                    attempt_fail = 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAIL:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (attempt_fail) begin
`ifdef PS2_TX_RETRY_EN
            if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
                retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                bit_cnt_d   = '0;
                inh_cnt_d   = '0;
                state_d     = ST_INHIBIT;
            end else begin
                state_d = ST_FAIL;
            end
`else
            state_d = ST_FAIL;
`endif
        end
    end

    assign next_bit = (bit_cnt_q < 4'd8) ? shreg_q[bit_cnt_q[2:0]] : par_q;

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        clk_low_d  = (state_d == ST_INHIBIT) || (state_d == ST_REQ);
        data_low_d = 1'b0;
        if (state_d == ST_REQ)
            data_low_d = 1'b1;
        else if (state_d == ST_SEND) begin
            if (state_q != ST_SEND)
                data_low_d = 1'b1;
            else if (clk_fall)
                data_low_d = ~next_bit;
            else
                data_low_d = data_low_q;
        end
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE) || (state_d == ST_FAIL);
        err_d   = (state_d == ST_FAIL);
    end

    assign ps2ClkLow  = clk_low_q;
    assign ps2DataLow = data_low_q;
    assign txReady    = ready_q;
    assign busy       = busy_q;
    assign txDone     = done_q;
    assign txErr      = err_q;

endmodule

// File: tb/tb_ps2_host_writer.sv
// Directed bench for ps2_host_writer with a behavioural PS/2 device on the
// open-drain lines; also builds with PS2_TX_RETRY_EN defined.
module tb_ps2_host_writer;

    localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
    localparam int NACK_FRAMES = 3;
`else
    localparam int NACK_FRAMES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2CLK, ps2DATA;
    logic       ps2ClkLow, ps2DataLow;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady, busy, txDone, txErr;
    logic       devClkLow, devDataLow;

    int   vectors = 0;
    int   miscompares = 0;
    int   doneCount = 0;
    logic lastErr, lastClkLow, lastDataLow;

    always #5 clk = ~clk;

    assign ps2CLK  = ~(ps2ClkLow | devClkLow);
    assign ps2DATA = ~(ps2DataLow | devDataLow);

    ps2_host_writer #(.CLK_HZ(1_000_000)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2CLK    (ps2CLK),
        .ps2DATA   (ps2DATA),
        .ps2ClkLow (ps2ClkLow),
        .ps2DataLow(ps2DataLow),
        .txData    (txData),
        .txValid   (txValid),
        .txReady   (txReady),
        .busy      (busy),
        .txDone    (txDone),
        .txErr     (txErr)
    );

    // Records every completion pulse together with the line state at that moment.
    always @(negedge clk) begin
        if (txDone) begin
            doneCount   = doneCount + 1;
            lastErr     = txErr;
            lastClkLow  = ps2ClkLow;
            lastDataLow = ps2DataLow;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        txData  = b;
        txValid = 1'b1;
        @(negedge clk);
        txValid = 1'b0;
    endtask

    task automatic measureInhibit(output int n);
        int guard;
        guard = 0;
        n = 0;
        while (!ps2DataLow && guard < 1000) begin
            if (ps2ClkLow) n++;
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic waitDone(input string tag, input int base, input int budget, output int cycles);
        cycles = 0;
        while (doneCount == base && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput(tag, 32'(doneCount > base), 32'd1);
    endtask

    // Device: samples DATA mid-high before each fall; optionally ACKs or resets the host at a fall.
    task automatic deviceFrame(input bit ack, input int rstAtFall, output logic [10:0] bits, output bit started);
        int guard;
        started = 1'b0;
        bits = '0;
        guard = 0;
        while (guard < 400) begin
            if (!ps2ClkLow && ps2DataLow) begin
                started = 1'b1;
                break;
            end
            @(negedge clk);
            guard++;
        end
        if (!started) return;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            repeat (HALF / 2) @(negedge clk);
            bits[i] = ps2DATA;
            if (i == 10 && ack) devDataLow = 1'b1;
            repeat (HALF / 2) @(negedge clk);
            devClkLow = 1'b1;
            if (i + 1 == rstAtFall) begin
                checkOutput("pre_rst_data_low", 32'(ps2DataLow), 32'd1);
                rst = 1'b1;
                @(negedge clk);
                checkOutput("rst_clk_released", 32'(ps2ClkLow), 32'd0);
                checkOutput("rst_data_released", 32'(ps2DataLow), 32'd0);
                checkOutput("rst_ready", 32'(txReady), 32'd1);
                checkOutput("rst_no_done", 32'(txDone), 32'd0);
                rst = 1'b0;
                repeat (HALF) @(negedge clk);
                devClkLow = 1'b0;
                return;
            end
            repeat (HALF) @(negedge clk);
            devClkLow = 1'b0;
        end
        repeat (HALF / 2) @(negedge clk);
        devDataLow = 1'b0;
    endtask

    initial begin
        logic [10:0] bits;
        logic [7:0]  bytesP [3];
        logic        parP   [3];
        bit          started;
        int          n, base, cyc;

        rst        = 1'b1;
        txValid    = 1'b0;
        txData     = 8'h00;
        devClkLow  = 1'b0;
        devDataLow = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_clk_low", 32'(ps2ClkLow), 32'd0);
        checkOutput("reset_data_low", 32'(ps2DataLow), 32'd0);
        checkOutput("reset_ready", 32'(txReady), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(txDone), 32'd0);
        checkOutput("reset_err", 32'(txErr), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] send 0xED with ACK");
        base = doneCount;
        applyStimulus(8'hED);
        checkOutput("ed_busy", 32'(busy), 32'd1);
        measureInhibit(n);
        checkOutput("ed_inhibit_cycles", 32'(n), 32'd100);
        checkOutput("ed_req_clk_low", 32'(ps2ClkLow), 32'd1);
        deviceFrame(1'b1, 0, bits, started);
        checkOutput("ed_started", 32'(started), 32'd1);
        checkOutput("ed_frame", 32'(bits), 32'h7DA);
        waitDone("ed_done", base, 200, cyc);
        checkOutput("ed_err", 32'(lastErr), 32'd0);
        @(negedge clk);
        checkOutput("ed_busy_after", 32'(busy), 32'd0);
        checkOutput("ed_ready_after", 32'(txReady), 32'd1);

        $display("[TB] parity edge bytes");
        bytesP[0] = 8'h00; parP[0] = 1'b1;
        bytesP[1] = 8'hFF; parP[1] = 1'b1;
        bytesP[2] = 8'h01; parP[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            base = doneCount;
            applyStimulus(bytesP[k]);
            deviceFrame(1'b1, 0, bits, started);
            checkOutput("par_started", 32'(started), 32'd1);
            checkOutput("par_bit", 32'(bits[9]), 32'(parP[k]));
            checkOutput("par_data", 32'(bits[8:1]), 32'(bytesP[k]));
            checkOutput("par_start_stop", 32'({bits[10], bits[0]}), 32'b10);
            waitDone("par_done", base, 200, cyc);
            checkOutput("par_err", 32'(lastErr), 32'd0);
            repeat (5) @(negedge clk);
        end

        $display("[TB] device NACK");
        base = doneCount;
        applyStimulus(8'hFF);
        for (int f = 0; f < NACK_FRAMES; f++) begin
            deviceFrame(1'b0, 0, bits, started);
            checkOutput("nack_frame_started", 32'(started), 32'd1);
            if (f < NACK_FRAMES - 1)
                checkOutput("nack_no_early_done", 32'(doneCount - base), 32'd0);
        end
        waitDone("nack_done", base, 200, cyc);
        checkOutput("nack_done_count", 32'(doneCount - base), 32'd1);
        checkOutput("nack_err", 32'(lastErr), 32'd1);
        repeat (5) @(negedge clk);

        $display("[TB] device silent after request");
        base = doneCount;
        applyStimulus(8'hF4);
        measureInhibit(n);
        checkOutput("to_inhibit_cycles", 32'(n), 32'd100);
        waitDone("to_done", base, NACK_FRAMES * 15300, cyc);
`ifndef PS2_TX_RETRY_EN
        checkOutput("to_latency", 32'(cyc >= 15000 && cyc <= 15004), 32'd1);
`endif
        checkOutput("to_err", 32'(lastErr), 32'd1);
        checkOutput("to_clk_released", 32'(lastClkLow), 32'd0);
        checkOutput("to_data_released", 32'(lastDataLow), 32'd0);
        repeat (5) @(negedge clk);

        $display("[TB] reset at fall 5");
        base = doneCount;
        applyStimulus(8'h00);
        deviceFrame(1'b1, 5, bits, started);
        checkOutput("rst_started", 32'(started), 32'd1);
        repeat (60) @(negedge clk);
        checkOutput("rst_never_done", 32'(doneCount - base), 32'd0);
        checkOutput("rst_idle_ready", 32'(txReady), 32'd1);

        $display("[TB] txValid pulse while busy");
        base = doneCount;
        applyStimulus(8'hF4);
        fork
            deviceFrame(1'b1, 0, bits, started);
            begin
                repeat (200) @(negedge clk);
                checkOutput("mid_ready_low", 32'(txReady), 32'd0);
                txData  = 8'h12;
                txValid = 1'b1;
                @(negedge clk);
                txValid = 1'b0;
                checkOutput("mid_still_busy", 32'(busy), 32'd1);
            end
        join
        checkOutput("mid_started", 32'(started), 32'd1);
        checkOutput("mid_frame", 32'(bits), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
        waitDone("mid_done", base, 200, cyc);
        checkOutput("mid_err", 32'(lastErr), 32'd0);
        repeat (30) @(negedge clk);
        checkOutput("mid_not_queued", 32'(busy), 32'd0);
        checkOutput("mid_single_done", 32'(doneCount - base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
